// File: rtl/yuv_to_axis.sv
// YUV422 capture stream to AXI4-Stream video with a FIFO and frame/line framing.
// States: SYNC wait vsync high | WAIT wait vsync low | ACTIVE accept pixels | DROP discard until vsync high
module yuv_to_axis #(
  parameter int LINE_WIDTH = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel,
  input  logic        we,
  input  logic        href,
  input  logic        vsync,
  output logic [15:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic        overflow,
  output logic        line_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {SYNC, WAIT, ACTIVE, DROP} state_t;

  state_t        r_state;
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [CW-1:0] r_col;
  logic          r_sof_pend;
  logic          r_href_d;
  logic          r_overflow;
  logic          r_line_err;
  logic          r_tvalid;
  logic          r_tuser;
  logic          r_tlast;
  logic [15:0]   r_tdata;

  logic          w_full;
  logic          w_wr_try;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_eol;
  logic          w_href_fall;
  logic [AW:0]   w_wr_nxt;
  logic [AW:0]   w_rd_nxt;
  logic [17:0]   w_entry;
  logic [17:0]   w_head_nxt;

  // Full uses the registered pointers only, so a same-cycle pop never rescues a write.
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_try    = (r_state == ACTIVE) && we && href;
  assign w_wr_en     = w_wr_try && !w_full;
  assign w_rd_en     = r_tvalid && m_axis_video_tready;
  assign w_eol       = (r_col == LAST_COL);
  assign w_entry     = {r_sof_pend, w_eol, pixel};
  assign w_wr_nxt    = r_wr_ptr + (AW+1)'(w_wr_en);
  assign w_rd_nxt    = r_rd_ptr + (AW+1)'(w_rd_en);
  assign w_href_fall = r_href_d && !href;
  assign w_head_nxt  = (w_wr_en && (w_rd_nxt == r_wr_ptr)) ? w_entry
                                                           : r_mem[w_rd_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SYNC;
      r_col      <= '0;
      r_sof_pend <= 1'b1;
      r_href_d   <= 1'b0;
      r_overflow <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_href_d <= href;
      if (w_wr_en) begin
        r_col      <= w_eol ? '0 : r_col + CW'(1);
        r_sof_pend <= 1'b0;
      end
      if (w_wr_try && w_full) r_overflow <= 1'b1;
      case (r_state)
        SYNC: if (vsync) r_state <= WAIT;
        WAIT: begin
          if (!vsync) begin
            r_state    <= ACTIVE;
            r_col      <= '0;
            r_sof_pend <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vsync) begin
            r_state <= WAIT;
            r_col   <= '0;
          end else if (w_wr_try && w_full) begin
            r_state <= DROP;
          end else if (w_href_fall && (r_col != '0)) begin
            r_col      <= '0;
            r_line_err <= 1'b1;
          end
        end
        DROP: if (vsync) r_state <= WAIT;
        default: r_state <= SYNC;
      endcase
    end
  end

  // Output stage registers the next FIFO head, bypassing the memory when it is written this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_tvalid <= (w_wr_nxt != w_rd_nxt);
      {r_tuser, r_tlast, r_tdata} <= w_head_nxt;
    end
  end

  assign m_axis_video_tdata  = r_tdata;
  assign m_axis_video_tvalid = r_tvalid;
  assign m_axis_video_tuser  = r_tuser;
  assign m_axis_video_tlast  = r_tlast;
  assign overflow            = r_overflow;
  assign line_err            = r_line_err;

endmodule
